// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants and fetch-stage types for the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        READY = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Program counter register with hold / step / redirect selection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] STEP     = PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    // Redirect wins over a sequential step issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_target;
        end else if (i_advance) begin
            r_pc <= r_pc + STEP;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch stage feeding the IF/ID register, one read in flight.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter logic [XLEN-1:0] PC_STEP   = cpu_pkg::PC_STEP
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instruction_o,
    output logic            valid_o,
    output logic [XLEN-1:0] fetch_count_o
);

    localparam logic [XLEN-1:0] c_one = 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_buf;
    logic [XLEN-1:0] r_fetch_count;
    logic [XLEN-1:0] w_pc;
    logic            w_ready;
    logic            w_redirect;
    logic            w_advance;

    assign w_ready    = (r_state == READY);
    assign w_redirect = branch_taken_i && (r_state != IDLE);
    assign w_advance  = w_ready && pc_write_i && !branch_taken_i;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .STEP     (PC_STEP)
    ) u_pc_gen (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_redirect (w_redirect),
        .i_target   (branch_target_i),
        .i_advance  (w_advance),
        .o_pc       (w_pc)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  w_state_next = FETCH;
            // The request issued in FETCH is already in flight, so a redirect must drain it.
            FETCH: w_state_next = branch_taken_i ? DRAIN : WAIT;
            WAIT: begin
                if (imem_ack_i) begin
                    w_state_next = branch_taken_i ? FETCH : READY;
                end else if (branch_taken_i) begin
                    w_state_next = DRAIN;
                end
            end
            READY: begin
                if (branch_taken_i || pc_write_i) begin
                    w_state_next = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack_i) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_buf         <= NOP_INSTR;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == WAIT) && imem_ack_i && !branch_taken_i) begin
                r_buf <= imem_rdata_i;
            end
            if (w_advance) begin
                r_fetch_count <= r_fetch_count + c_one;
            end
        end
    end

    assign imem_req_o    = (r_state == FETCH);
    assign imem_addr_o   = w_pc;
    assign valid_o       = w_ready;
    assign instruction_o = w_ready ? r_buf : NOP_INSTR;
    assign pc_o          = w_pc;
    assign fetch_count_o = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
    logic [31:0] fetch_count;

    if_fetch_unit #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_rdata_i    (imem_rdata),
        .pc_o            (pc),
        .instruction_o   (instruction),
        .valid_o         (valid),
        .fetch_count_o   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: where the next fetch should come from, what is on offer, what is in flight.
    logic [31:0] exp_pc;
    logic [31:0] accept_count;
    logic [31:0] req_addr;
    bit          presenting;
    bit          exp_req;
    bit          outstanding;
    bit          squash;
    bit          idle_now;
    bit          spur_en;
    bit          force_spur;
    int          age;
    int          ack_delay;
    int          fixed_delay;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("addr", imem_addr, exp_pc);
        chk("valid", {31'b0, valid}, {31'b0, presenting});
        chk("pc", pc, exp_pc);
        chk("instr", instruction, presenting ? mem(exp_pc) : NOP);
        chk("count", fetch_count, accept_count);
    endtask

    task automatic check_reset_values();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_count", fetch_count, 32'd0);
    endtask

    task automatic model_reset();
        exp_pc       = RESET_PC;
        accept_count = '0;
        presenting   = 1'b0;
        exp_req      = 1'b0;
        outstanding  = 1'b0;
        squash       = 1'b0;
        idle_now     = 1'b1;
        age          = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample and check after the edge.
    task automatic tick(input bit br, input logic [31:0] tgt, input bit pw);
        bit ack_real;
        bit nxt_req;
        bit nxt_pres;
        ack_real   = outstanding && (age == ack_delay);
        imem_ack   = ack_real;
        imem_rdata = $urandom;
        if (!outstanding || age == 0)
            imem_ack = force_spur || (spur_en && ($urandom_range(0, 3) == 0));
        if (ack_real && !squash && !br) imem_rdata = mem(req_addr);
        branch_taken  = br;
        branch_target = tgt;
        pc_write      = pw;

        nxt_req  = 1'b0;
        nxt_pres = presenting;
        if (idle_now) begin
            nxt_req = 1'b1;
        end else if (br) begin
            exp_pc   = tgt;
            nxt_pres = 1'b0;
            if (outstanding) begin
                if (ack_real) begin
                    outstanding = 1'b0;
                    squash      = 1'b0;
                    nxt_req     = 1'b1;
                end else begin
                    squash = 1'b1;
                end
            end else begin
                nxt_req = 1'b1;
            end
        end else begin
            if (ack_real) begin
                outstanding = 1'b0;
                if (squash) nxt_req = 1'b1;
                else        nxt_pres = 1'b1;
                squash = 1'b0;
            end
            if (presenting && pw) begin
                accept_count = accept_count + 32'd1;
                exp_pc       = exp_pc + 32'd4;
                nxt_pres     = 1'b0;
                nxt_req      = 1'b1;
            end
        end
        if (outstanding) age++;
        idle_now   = 1'b0;
        force_spur = 1'b0;
        presenting = nxt_pres;
        exp_req    = nxt_req;

        @(posedge clk);
        #1;
        check_outputs();
        if (imem_req === 1'b1) begin
            outstanding = 1'b1;
            req_addr    = imem_addr;
            age         = 0;
            squash      = 1'b0;
            ack_delay   = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
        end
    endtask

    task automatic wait_presenting();
        for (int i = 0; i < 20; i++) begin
            if (presenting) break;
            tick(1'b0, 32'h0, 1'b0);
        end
        chk("present_timeout", {31'b0, valid}, 32'd1);
    endtask

    task automatic wait_request();
        for (int i = 0; i < 20; i++) begin
            if (outstanding && age == 0) break;
            tick(1'b0, 32'h0, 1'b1);
        end
        chk("request_timeout", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        logic [31:0] saved;
        rst           = 1'b1;
        pc_write      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        spur_en       = 1'b0;
        force_spur    = 1'b0;
        fixed_delay   = 1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();

        // Release reset; the branch seen in the IDLE cycle must be ignored.
        rst = 1'b0;
        model_reset();
        tick(1'b1, 32'h0000_0500, 1'b1);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        chk("first_valid", {31'b0, valid}, 32'd1);
        chk("first_instr", instruction, 32'h0050_0093);
        chk("first_pc", pc, 32'h0);
        tick(1'b0, 32'h0, 1'b1);
        chk("second_addr", imem_addr, 32'h4);
        chk("count_after_accept", fetch_count, 32'd1);

        // Stall in READY for five cycles.
        wait_presenting();
        saved = exp_pc;
        repeat (5) tick(1'b0, 32'h0, 1'b0);
        chk("stall_pc", pc, saved);
        tick(1'b0, 32'h0, 1'b1);
        chk("stall_release_addr", imem_addr, saved + 32'd4);

        // Redirect from READY.
        wait_presenting();
        saved = accept_count;
        tick(1'b1, 32'h0000_0100, 1'b1);
        chk("br_ready_valid", {31'b0, valid}, 32'd0);
        chk("br_ready_addr", imem_addr, 32'h0000_0100);
        chk("br_ready_count", fetch_count, saved);

        // Redirect in WAIT with the ack three cycles after the request.
        wait_presenting();
        fixed_delay = 3;
        wait_request();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h0000_0200, 1'b0);
        wait_request();
        chk("drain_addr", imem_addr, 32'h0000_0200);

        // Redirect and ack in the same WAIT cycle.
        wait_presenting();
        fixed_delay = 1;
        wait_request();
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h0000_0300, 1'b0);
        chk("br_ack_req", {31'b0, imem_req}, 32'd1);
        chk("br_ack_addr", imem_addr, 32'h0000_0300);

        // Asynchronous reset in WAIT, with ack arriving during and just after reset.
        wait_presenting();
        fixed_delay = 3;
        wait_request();
        tick(1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        model_reset();
        force_spur = 1'b1;
        tick(1'b0, 32'h0, 1'b1);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_count", fetch_count, 32'd0);

        // PC wrap-around.
        fixed_delay = 1;
        wait_presenting();
        tick(1'b1, 32'hFFFF_FFFC, 1'b0);
        wait_presenting();
        tick(1'b0, 32'h0, 1'b1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic: variable latency, stray acks, random stalls and redirects.
        spur_en     = 1'b1;
        fixed_delay = 0;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Producer side of the IF/ID interface.
- Owns the program counter and issues one instruction-memory read at a time over a request/acknowledge handshake.
- Presents the fetched pc/instruction pair with a valid flag to the IF/ID pipeline register.
- Honours hazard-unit stalls and branch redirects; on a redirect it squashes wrong-path data, including a read still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction is presented.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- pc_write_i  in  1  hazard unit: 1 = consumer accepts the presented instruction this cycle; 0 = stall
- branch_taken_i  in  1  redirect request from execute
- branch_target_i  in  32  redirect PC
- imem_req_o  out  1  read request, one-cycle pulse
- imem_addr_o  out  32  read address, valid while imem_req_o=1
- imem_ack_i  in  1  read data valid, earliest one cycle after the request
- imem_rdata_i  in  32  read data
- pc_o  out  32  PC of the presented instruction (to IF/ID pc_i)
- instruction_o  out  32  presented instruction (to IF/ID instruction_i)
- valid_o  out  1  1 = instruction_o is real; 0 = bubble
- fetch_count_o  out  32  number of instructions accepted downstream

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE, pc_q = RESET_PC, buf_q = NOP_INSTR, fetch_count_o = 0.
  - Outputs: imem_req_o = 0, valid_o = 0, instruction_o = NOP_INSTR, pc_o = RESET_PC.
- States: IDLE, FETCH, WAIT, READY, DRAIN. All outputs decode from registered state.
- Transitions:
  - IDLE: unconditional -> FETCH. The first request is issued one cycle after reset release.
  - FETCH: imem_req_o = 1 and imem_addr_o = pc_q for exactly one cycle, then -> WAIT.
  - WAIT: on imem_ack_i, buf_q <= imem_rdata_i and -> READY; otherwise stay.
  - READY: valid_o = 1, instruction_o = buf_q, pc_o = pc_q.
    - If pc_write_i = 1: pc_q <= pc_q + PC_STEP (mod 2^32), fetch_count_o += 1 (wraps), -> FETCH.
    - If pc_write_i = 0: hold all outputs stable.
  - DRAIN: wait for the ack of the squashed read, discard imem_rdata_i, -> FETCH.
- Redirect (branch_taken_i = 1) has priority over every other event in FETCH, WAIT, READY and DRAIN:
  - pc_q <= branch_target_i; no fetch_count_o increment.
  - From FETCH: -> DRAIN (the request issued this cycle is in flight).
  - From WAIT without ack: -> DRAIN.
  - From WAIT with ack in the same cycle: data discarded, -> FETCH.
  - From READY: buffered instruction squashed, -> FETCH, regardless of pc_write_i.
  - From DRAIN: target updated; without ack stay in DRAIN, with ack -> FETCH.
  - branch_taken_i in IDLE: ignored.
- Outside READY: valid_o = 0, instruction_o = NOP_INSTR, pc_o = pc_q.
- Latency: with single-cycle memory (ack the cycle after the request), valid_o rises 2 cycles after the FETCH cycle. Sustained throughput is 1 instruction per 3 cycles.
- imem_ack_i arriving in IDLE, FETCH or READY is ignored. This covers an ack left over from a read cut off by reset.
- pc_write_i is don't-care outside READY.
- Mid-operation reset: immediate return to reset values. No request is issued while rst_i = 1.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum (IDLE, FETCH, WAIT, READY, DRAIN).
  - NOP_INSTR and PC_STEP constants.
  - XLEN = 32, shared with IF/ID and the hazard unit.
- One natural sub-module, fetch_pc_gen: PC register plus next-PC mux (hold / +PC_STEP / branch target).
- The FSM, instruction buffer and counter stay in the top level.

Test Plan:
- Reset then single-cycle memory, pc_write_i = 1, mem[0] = 32'h0050_0093, mem[4] = 32'h00A0_0113:
  - imem_req_o at cycle 1 with addr 0.
  - valid_o at cycle 3 with instruction_o = 32'h0050_0093, pc_o = 0.
  - Next request at addr 4.
  - fetch_count_o = 1 after acceptance.
- Stall: in READY hold pc_write_i = 0 for 5 cycles -> pc_o, instruction_o and valid_o stable, no imem_req_o, fetch_count_o unchanged. Release -> request at pc + 4.
- Branch in READY, target 32'h0000_0100 -> valid_o = 0 next cycle, next request addr = 32'h100, squashed instruction not counted.
- Branch in WAIT with ack delayed 3 cycles, target 32'h200 -> DRAIN, returned data never appears on instruction_o, then request at addr 32'h200.
- Branch and ack in the same WAIT cycle -> data dropped, next cycle FETCH at the target.
- Async reset asserted mid-WAIT, ack arrives during reset -> ack ignored, first request after release is at RESET_PC, fetch_count_o = 0.
- Wrap: branch to 32'hFFFF_FFFC, accept -> next request addr = 32'h0000_0000.
